bus_mux_rr: RTL
===============

Name: bus_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit bus multiplexer with a registered output stage and valid/ready handshakes on every input and on the output.
- Two modes: fixed select (software/decoder-driven `sel`) or round-robin arbitration among requesting channels.
- Sits between datapath sources (register file ports, ALU, immediate, memory data) and shared consumers such as the write-back bus.
- Replaces hard-wired 8:1 16-bit source selection and adds flow control.

Parameters:
- WIDTH, 16, data width per channel.
- NUM_IN, 8, number of input channels (2..16).
- SEL_W, clog2(NUM_IN) (derived, min 1), width of `sel` / `out_src`.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  flattened inputs; channel i at [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-channel data valid.
- in_ready  out  NUM_IN  per-channel accept; at most one bit high.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used in mode 0.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  out_data holds an unconsumed beat.
- out_ready  in  1  consumer accepts beat.
- out_src  out  SEL_W  channel index that produced out_data.
- sel_err  out  1  registered flag: previous cycle had mode=0 with sel >= NUM_IN.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_src=0, sel_err=0, rr pointer ptr=0. Any held beat is discarded; no in_ready asserted while rst=1.
- Load condition: load = !out_valid || out_ready.
- Grant, mode 0: grant to channel `sel` iff sel < NUM_IN and in_valid[sel]. All other channels are ignored.
- Grant, mode 1: search channels ptr, ptr+1, … wrapping modulo NUM_IN. The first with in_valid=1 wins. No grant if in_valid is all zero.
- in_ready[g] = load && grant; combinational, so it depends on out_ready, mode, sel and in_valid in the same cycle. All other in_ready bits are 0.
- Transfer (load && grant), next edge: out_data <= channel g, out_src <= g, out_valid <= 1. In mode 1 also ptr <= (g+1) mod NUM_IN, with explicit wrap for non-power-of-2 NUM_IN.
- Load without grant: out_valid <= 0; out_data/out_src hold their last values.
- Stall (out_valid && !out_ready): all in_ready = 0; out_data, out_src, out_valid and ptr are stable.
- Latency: one cycle from input acceptance to out_valid. Throughput: one beat per cycle when out_ready is held high.
- Mode 0 never modifies ptr. A mode switch takes effect in the cycle it is sampled, and the beat already in the output register is unaffected.
- sel_err <= (mode==0 && sel >= NUM_IN) each cycle, independent of in_valid and load. No transfer occurs in that cycle. Only reachable when NUM_IN is not a power of 2.
- A channel with in_valid high must hold its data until its in_ready is seen. The block does not buffer more than one beat.

Decomposition:
- Shared package: MODE_FIXED=1'b0, MODE_RR=1'b1, and the clog2 helper function used to derive SEL_W.
- Sub-module bus_rr_arbiter, purely combinational:
  - inputs: req[NUM_IN], ptr;
  - outputs: grant_valid, grant_idx;
  - implements the rotating priority search.
- Top level owns ptr, the output register, mode/sel muxing and sel_err.

Test Plan:
- Reset mid-stream: out_valid=1 with out_data=0x1234, assert rst asynchronously between edges → out_valid=0, out_data=0x0000, out_src=0, sel_err=0 immediately; the first RR grant after release is channel 0.
- Fixed select (NUM_IN=8, WIDTH=16): mode=0, sel=3, ch3=0xBEEF, in_valid=8'hFF, out_ready=1 → in_ready=8'b0000_1000. Next cycle out_data=0xBEEF, out_src=3, out_valid=1.
- Round-robin full load: mode=1, in_valid=8'hFF for 9 cycles, out_ready=1 → out_src sequence 0,1,2,3,4,5,6,7,0; one beat per cycle.
- Sparse round-robin: mode=1, ptr=0, in_valid=8'b1000_0010 → grants 1,7,1,7; ptr reads 2,0,2,0 after each grant.
- Backpressure: output holding 0x00AA, out_ready=0 for 3 cycles with ch2 valid=0x0055 → out_data stays 0x00AA and in_ready=0. Raise out_ready → 0x00AA consumed, ch2 accepted the same cycle, out_data=0x0055 next cycle.
- Invalid select (NUM_IN=6 instance): mode=0, sel=7, all valid → in_ready=0, next cycle sel_err=1 and out_valid=0. Set sel=2 → sel_err=0 the following cycle.

Source files
------------

// File: rtl/bus_mux_rr_pkg.sv
// Shared definitions for the bus_mux_rr multiplexer: mode encodings and the
// select-width helper used to size channel indices.
package bus_mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for n channels, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Rotating-priority search: the first requester at or after ptr, wrapping
// modulo NUM_IN, wins. Purely combinational.
module bus_rr_arbiter
    import bus_mux_rr_pkg::*;
#(
    parameter int NUM_IN = 8,
    parameter int SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              grant_valid,
    output logic [SEL_W-1:0]  grant_idx
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam logic [SEL_W:0] NUM_IN_EXT = (SEL_W+1)'(NUM_IN);

    logic [SEL_W:0] cand;

    always_comb begin
        // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        // Walk from the farthest offset down so the nearest requester is written last.
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (SEL_W+1)'(k);
            if (cand >= NUM_IN_EXT) begin
                cand = cand - NUM_IN_EXT;
            end
            if (req[cand[SEL_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_mux_rr.sv
// N-channel bus multiplexer with a one-beat registered output, valid/ready
// flow control, and either fixed-select or round-robin channel choice.
module bus_mux_rr
    import bus_mux_rr_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src,
    output logic                    sel_err
);

    localparam logic [SEL_W:0]   NUM_IN_EXT = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_IN - 1);

    logic [WIDTH-1:0] ch_data [NUM_IN];
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;

    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             sel_in_range;
    logic             load;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            ch_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    bus_rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req         (in_valid),
        .ptr         (ptr_q),
        .grant_valid (rr_valid),
        .grant_idx   (rr_idx)
    );

    assign sel_in_range = ({1'b0, sel} < NUM_IN_EXT);
    assign load         = !out_valid_q || out_ready;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = sel;
        if (mode == MODE_RR) begin
            grant_valid = rr_valid;
            grant_idx   = rr_idx;
        end else if (sel_in_range) begin
            grant_valid = in_valid[sel];
        end
    end

    // Accept is gated by reset so no source hands off a beat that would be dropped.
    always_comb begin
        in_ready = '0;
        if (load && grant_valid && !rst) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        sel_err_d   = (mode == MODE_FIXED) && !sel_in_range;
        if (load) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                out_data_d = ch_data[grant_idx];
                out_src_d  = grant_idx;
                if (mode == MODE_RR) begin
                    ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    assign sel_err   = sel_err_q;

endmodule
